bitwise_logic_pipe: RTL and testbench
=====================================

# bitwise_logic_pipe

Parametrised, pipelined two-operand bitwise logic unit: the registered, multi-op, multi-bit successor to the single-bit 2-input gate examples. Accepts operand pairs with a selectable operation over a valid/ready handshake, computes the result at the input stage and carries it through DEPTH bubble-collapsing pipeline stages. It also keeps a transaction counter for bench bookkeeping. It sits between a test-vector driver (or upstream datapath) and any consumer that can apply backpressure.

## Interface
- WIDTH, 8, operand/result width in bits (>= 1)
- DEPTH, 2, number of pipeline register stages (>= 1); also the latency in cycles
- CNTW, 16, width of the completed-transaction counter
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  operand pair and op are valid
- in_ready  output  1  unit can accept this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  3  operation select
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- y  output  WIDTH  result
- y_zero  output  1  y == 0
- op_err  output  1  result came from an unsupported op
- out_cnt  output  CNTW  count of results accepted downstream

## Operation
- One clock; reset is asynchronous and active-low: rst_n low immediately clears all state regardless of clk.
- Op encoding: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 RAND (y = {WIDTH-1 zeros, &a}), 111 ROR (y = {WIDTH-1 zeros, |a}). b is ignored for 110/111.
- Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Result, y_zero and op_err are computed combinationally from a/b/op and captured into stage 0 on input transfer; each stage holds {valid, y, y_zero, op_err}.
- Bubble collapse: stage i loads from stage i-1 when stage i is empty or stage i is advancing. The last stage advances on output transfer. Stage 0 loads on input transfer.
- in_ready = stage 0 empty or stage 0 advancing (combinational from out_ready through the chain; no registered skid).
- out_valid/y/y_zero/op_err come directly from the last stage's registers.
- out_cnt increments by 1 on each output transfer and wraps modulo 2^CNTW (all-ones -> 0).
- in_valid without in_ready: the source must hold a/b/op stable; the unit samples nothing.
- out_valid held with y stable until out_ready (no retraction).

## Timing
- Reset values: in_ready 1 (after rst_n release; 1 during reset is permitted), out_valid 0, y 0, y_zero 0, op_err 0, out_cnt 0; all stage valids 0.
- Latency: input transfer at edge N -> out_valid high after edge N+DEPTH-1 (data visible DEPTH cycles after presentation, first observable cycle following edge N+DEPTH-1), with no stalls.
- Throughput: 1 result/cycle with out_ready held high.
- Full: all DEPTH stages valid and out_ready low -> in_ready low same cycle.
- Simultaneous full + out_ready high -> in_ready high; input accepted same edge as output leaves (no bubble).
- Bubbles are removed: after a stall with gaps, stages compact toward the output.
- Reset mid-operation: all in-flight results discarded; out_cnt cleared; no output transfer reported after rst_n falls.

## Configuration
- REDUCE_OPS_EN defined: ops 110/111 perform RAND/ROR as above; op_err always 0.
- REDUCE_OPS_EN undefined: ops 110/111 unsupported; y = 0, y_zero = 1, op_err = 1 for that result. The result still occupies a pipeline slot and counts in out_cnt. The reduction logic is not synthesised.

## Test plan
- Reset: assert rst_n=0 mid-stream with 2 results in flight -> out_valid 0, y 0, out_cnt 0 immediately. After release, first vector emerges only after a fresh DEPTH-cycle latency.
- Op sweep (WIDTH=8, DEPTH=2, out_ready=1): a=8'hF0, b=8'h3C, ops 000-101 -> y = 30, FC, CC, CF, 03, 33. Each appears 2 cycles after input, back-to-back. y_zero=0 throughout.
- Reductions: a=8'hFF op 110 -> y=01. a=8'h00 op 111 -> y=00, y_zero=1. With REDUCE_OPS_EN undefined, both -> y=00, y_zero=1, op_err=1.
- Backpressure: out_ready=0 while driving 3 vectors -> 2 accepted, in_ready 0 on the third. Raise out_ready -> results appear in order, third accepted same cycle first leaves, out_cnt=3 at end.
- Bubble collapse: inject vectors at cycles 0 and 2 with out_ready=0 -> both stages fill (in_ready 0). Release -> 2 consecutive out_valid cycles.
- Counter wrap: CNTW=4, stream 17 results -> out_cnt reads 1.

Source files
------------

// File: rtl/bitwise_logic_pipe.sv
// Pipelined two-operand bitwise logic unit with valid/ready handshake and bubble-collapsing stages.
// Optional macro REDUCE_OPS_EN enables the RAND/ROR reduction ops (110/111).
module bitwise_logic_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_zero,
    output logic             op_err,
    output logic [CNTW-1:0]  out_cnt
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_RAND = 3'b110,
        OP_ROR  = 3'b111
    } op_e;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             zero;
        logic             err;
    } res_t;

    res_t            res_d;
    logic [DEPTH-1:0] vld_q;
    res_t            dat_q [DEPTH];
    logic [DEPTH-1:0] ld;
    logic            in_xfer;
    logic            out_xfer;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        res_d = '0;
        unique case (op_e'(op))
            OP_AND:  res_d.y = a & b;
            OP_OR:   res_d.y = a | b;
            OP_XOR:  res_d.y = a ^ b;
            OP_NAND: res_d.y = ~(a & b);
            OP_NOR:  res_d.y = ~(a | b);
            OP_XNOR: res_d.y = ~(a ^ b);
`ifdef REDUCE_OPS_EN
            OP_RAND: res_d.y[0] = &a;
            OP_ROR:  res_d.y[0] = |a;
`else
            OP_RAND: res_d.err = 1'b1;
            OP_ROR:  res_d.err = 1'b1;
`endif
            default: res_d.err = 1'b1;
        endcase
        res_d.zero = (res_d.y == '0);
    end

    // A stage may load when it, or any stage between it and the output, has room to move.
    always_comb begin
        ld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ld[i] = out_ready;
            for (int j = i; j < DEPTH; j++) begin
                if (!vld_q[j]) ld[i] = 1'b1;
            end
        end
    end

    assign in_ready = ld[0];
    assign in_xfer  = in_valid && ld[0];
    assign out_xfer = vld_q[DEPTH-1] && out_ready;
    assign cnt_d    = cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the stage array is tiny, so it is reset along with the valids to keep y at 0 after reset.
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
            cnt_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every stage samples pre-edge values.
            if (ld[0]) begin
                vld_q[0] <= in_xfer;
                if (in_xfer) dat_q[0] <= res_d;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (ld[i]) begin
                    vld_q[i] <= vld_q[i-1];
                    if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
                end
            end
            if (out_xfer) cnt_q <= cnt_d;
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign y         = dat_q[DEPTH-1].y;
    assign y_zero    = dat_q[DEPTH-1].zero;
    assign op_err    = dat_q[DEPTH-1].err;
    assign out_cnt   = cnt_q;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Directed, table-driven bench for bitwise_logic_pipe (WIDTH=8, DEPTH=2, CNTW=4).
// Expected values follow REDUCE_OPS_EN when it is defined for the build.
module tb_bitwise_logic_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CNTW  = 4;
    localparam int NSW   = 10;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             y_zero;
    logic             op_err;
    logic [CNTW-1:0]  out_cnt;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] y;
        logic       yz;
        logic       err;
    } vec_t;

    vec_t sweep [NSW];
    int   n_checks = 0;
    int   n_fail   = 0;

    bitwise_logic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_zero    (y_zero),
        .op_err    (op_err),
        .out_cnt   (out_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        a        = v.a;
        b        = v.b;
        op       = v.op;
    endtask

    task automatic check_out(input string name, input vec_t v);
        check({name, ".valid"}, 32'(out_valid), 32'd1);
        check({name, ".y"}, 32'(y), 32'(v.y));
        check({name, ".y_zero"}, 32'(y_zero), 32'(v.yz));
        check({name, ".op_err"}, 32'(op_err), 32'(v.err));
    endtask

    initial begin
        sweep[0] = '{8'hF0, 8'h3C, 3'b000, 8'h30, 1'b0, 1'b0};
        sweep[1] = '{8'hF0, 8'h3C, 3'b001, 8'hFC, 1'b0, 1'b0};
        sweep[2] = '{8'hF0, 8'h3C, 3'b010, 8'hCC, 1'b0, 1'b0};
        sweep[3] = '{8'hF0, 8'h3C, 3'b011, 8'hCF, 1'b0, 1'b0};
        sweep[4] = '{8'hF0, 8'h3C, 3'b100, 8'h03, 1'b0, 1'b0};
        sweep[5] = '{8'hF0, 8'h3C, 3'b101, 8'h33, 1'b0, 1'b0};
        sweep[6] = '{8'h5A, 8'h5A, 3'b010, 8'h00, 1'b1, 1'b0};
        sweep[7] = '{8'hFF, 8'hFF, 3'b011, 8'h00, 1'b1, 1'b0};
`ifdef REDUCE_OPS_EN
        sweep[8] = '{8'hFF, 8'h00, 3'b110, 8'h01, 1'b0, 1'b0};
        sweep[9] = '{8'h00, 8'hFF, 3'b111, 8'h00, 1'b1, 1'b0};
`else
        sweep[8] = '{8'hFF, 8'h00, 3'b110, 8'h00, 1'b1, 1'b1};
        sweep[9] = '{8'h00, 8'hFF, 3'b111, 8'h00, 1'b1, 1'b1};
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        out_ready = 1'b0;
        #2;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.y", 32'(y), 32'd0);
        check("reset.y_zero", 32'(y_zero), 32'd0);
        check("reset.op_err", 32'(op_err), 32'd0);
        check("reset.out_cnt", 32'(out_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset.in_ready", 32'(in_ready), 32'd1);

        // Op sweep: back-to-back with out_ready high; result k visible two negedges after it is driven.
        out_ready = 1'b1;
        for (int c = 0; c < NSW + 2; c++) begin
            @(negedge clk);
            check("sweep.valid", 32'(out_valid), 32'(c >= 2));
            if (c >= 2) check_out($sformatf("sweep[%0d]", c - 2), sweep[c - 2]);
            if (c < NSW) drive(sweep[c]);
            else in_valid = 1'b0;
            #1;
            check("sweep.in_ready", 32'(in_ready), 32'd1);
        end
        @(negedge clk);
        check("sweep.drained", 32'(out_valid), 32'd0);
        check("sweep.out_cnt", 32'(out_cnt), 32'd10);

        // Backpressure: two vectors fill the pipe, the third waits until the first leaves.
        out_ready = 1'b0;
        drive(sweep[0]);
        #1 check("bp.rdy0", 32'(in_ready), 32'd1);
        @(negedge clk);
        drive(sweep[1]);
        #1 check("bp.rdy1", 32'(in_ready), 32'd1);
        @(negedge clk);
        drive(sweep[2]);
        #1 check("bp.full", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("bp.still_full", 32'(in_ready), 32'd0);
        check_out("bp.hold0", sweep[0]);
        out_ready = 1'b1;
        #1 check("bp.pass_through", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check_out("bp.out1", sweep[1]);
        @(negedge clk);
        check_out("bp.out2", sweep[2]);
        @(negedge clk);
        check("bp.drained", 32'(out_valid), 32'd0);
        check("bp.out_cnt", 32'(out_cnt), 32'd13);

        // Bubble collapse: gapped inputs under stall compact into both stages.
        out_ready = 1'b0;
        drive(sweep[3]);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1 check("bub.gap_ready", 32'(in_ready), 32'd1);
        drive(sweep[4]);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("bub.full", 32'(in_ready), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        check_out("bub.out0", sweep[3]);
        @(negedge clk);
        check_out("bub.out1", sweep[4]);
        @(negedge clk);
        check("bub.drained", 32'(out_valid), 32'd0);
        check("bub.out_cnt", 32'(out_cnt), 32'd15);

        // Reset with two results in flight.
        drive(sweep[0]);
        @(negedge clk);
        drive(sweep[1]);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.y", 32'(y), 32'd0);
        check("rst.out_cnt", 32'(out_cnt), 32'd0);
        @(negedge clk);
        check("rst.held_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;

        // Fresh latency after reset, then 17 results wrap the 4-bit counter to 1.
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            check("wrap.valid", 32'(out_valid), 32'(c >= 2 && c <= 18));
            if (c == 2) check_out("wrap.first", sweep[1]);
            if (c < 17) drive(sweep[1]);
            else in_valid = 1'b0;
        end
        @(negedge clk);
        check("wrap.drained", 32'(out_valid), 32'd0);
        check("wrap.out_cnt", 32'(out_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
